// File: rtl/mips_mc_if.sv
// Control-unit bus: instruction fields, ALU/memory status in, datapath strobes and selects out.
// The control unit uses the master modport; the datapath side uses slave.
interface mips_mc_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [3:0] alu_ctl;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       ext_zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output alu_ctl, alusrca, alusrcb, ext_zero, iord, memwrite, irwrite,
           regdst, memtoreg, regwrite, pcsrc, pcen, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  alu_ctl, alusrca, alusrcb, ext_zero, iord, memwrite, irwrite,
           regdst, memtoreg, regwrite, pcsrc, pcen, illegal
  );
endinterface

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes datapath strobes, mux selects and the 4-bit ALU operation.
module mips_mc_control (
  input  logic         clk,
  input  logic         reset,
  mips_mc_if.master    bus
);
  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] RTEX   = 4'd6;
  localparam logic [3:0] RTWB   = 4'd7;
  localparam logic [3:0] BREX   = 4'd8;
  localparam logic [3:0] IMMEX  = 4'd9;
  localparam logic [3:0] IMMWB  = 4'd10;
  localparam logic [3:0] JEX    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd0;
  localparam logic [3:0] ALU_AND = 4'd10;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_XOR = 4'd13;
  localparam logic [3:0] ALU_SLT = 4'd7;

  logic [3:0] state, next_state;
  logic [5:0] op_q, funct_q;
  logic [3:0] rt_alu;
  logic       rt_legal;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // NOTE: op_q/funct_q are always loaded in DECODE before any later state reads them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == DECODE) begin
      op_q    <= bus.op;
      funct_q <= bus.funct;
    end
  end

  always_comb begin
    rt_legal = 1'b1;
    unique case (funct_q)
      6'b100000: rt_alu = ALU_ADD;
      6'b100010: rt_alu = ALU_SUB;
      6'b100100: rt_alu = ALU_AND;
      6'b100101: rt_alu = ALU_OR;
      6'b100110: rt_alu = ALU_XOR;
      6'b100111: rt_alu = ALU_NOR;
      6'b101010: rt_alu = ALU_SLT;
      default: begin
        rt_alu   = ALU_ADD;
        rt_legal = 1'b0;
      end
    endcase
  end

  // NOTE: every output gets a default at the top of this block, so no path can infer a latch.
  always_comb begin
    next_state   = FETCH;
    bus.alu_ctl  = ALU_ADD;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.ext_zero = 1'b0;
    bus.iord     = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.pcsrc    = 2'b00;
    bus.pcen     = 1'b0;
    bus.illegal  = 1'b0;

    case (state)
      FETCH: begin
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.mem_ready;
        bus.pcen    = bus.mem_ready;
        next_state  = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW:                                 next_state = MEMADR;
          OP_RTYPE:                                     next_state = RTEX;
          OP_BEQ, OP_BNE:                               next_state = BREX;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI:   next_state = IMMEX;
          OP_J:                                         next_state = JEX;
          default:                                      bus.illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        next_state  = (op_q == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.iord   = 1'b1;
        next_state = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
        next_state   = bus.mem_ready ? FETCH : MEMWR;
      end
      RTEX: begin
        bus.alusrca = 1'b1;
        bus.alu_ctl = rt_alu;
        bus.illegal = ~rt_legal;
        next_state  = rt_legal ? RTWB : FETCH;
      end
      RTWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      BREX: begin
        bus.alusrca = 1'b1;
        bus.alu_ctl = ALU_SUB;
        bus.pcsrc   = 2'b01;
        bus.pcen    = bus.zero ^ (op_q == OP_BNE);
      end
      IMMEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        next_state  = IMMWB;
        case (op_q)
          OP_SLTI: bus.alu_ctl = ALU_SLT;
          OP_ANDI: begin bus.alu_ctl = ALU_AND; bus.ext_zero = 1'b1; end
          OP_ORI:  begin bus.alu_ctl = ALU_OR;  bus.ext_zero = 1'b1; end
          OP_XORI: begin bus.alu_ctl = ALU_XOR; bus.ext_zero = 1'b1; end
          default: bus.alu_ctl = ALU_ADD;
        endcase
      end
      IMMWB: begin
        bus.regwrite = 1'b1;
      end
      JEX: begin
        bus.pcsrc = 2'b10;
        bus.pcen  = 1'b1;
      end
      default: next_state = FETCH;
    endcase

    // Nothing may be written or loaded while reset is held.
    if (reset) begin
      bus.memwrite = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regwrite = 1'b0;
      bus.pcen     = 1'b0;
      bus.illegal  = 1'b0;
    end
  end
endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: a per-instruction step model built from
// the instruction class rules, directed cases, then randomized instructions and stalls.
module tb_mips_mc_control;
  typedef struct packed {
    logic [3:0] alu_ctl;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       ext_zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    logic mr;
    ctl_t v;
    logic scr;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  step_t exp_q[$];

  mips_mc_if bus ();
  mips_mc_control dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic ctl_t observed();
    ctl_t c;
    c.alu_ctl  = bus.alu_ctl;
    c.alusrca  = bus.alusrca;
    c.alusrcb  = bus.alusrcb;
    c.ext_zero = bus.ext_zero;
    c.iord     = bus.iord;
    c.memwrite = bus.memwrite;
    c.irwrite  = bus.irwrite;
    c.regdst   = bus.regdst;
    c.memtoreg = bus.memtoreg;
    c.regwrite = bus.regwrite;
    c.pcsrc    = bus.pcsrc;
    c.pcen     = bus.pcen;
    c.illegal  = bus.illegal;
    return c;
  endfunction

  function automatic ctl_t idle();
    ctl_t c = '0;
    c.alu_ctl = 4'd2;
    return c;
  endfunction

  function automatic void push(logic mr, ctl_t v, logic scr);
    step_t s;
    s.mr = mr; s.v = v; s.scr = scr;
    exp_q.push_back(s);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // R-type ALU code by funct, or -1 for an unsupported funct.
  function automatic int rt_code(logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 0;
      6'b100100: return 10;
      6'b100101: return 1;
      6'b100110: return 13;
      6'b100111: return 12;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  // Expected cycle-by-cycle outputs for one whole instruction.
  function automatic void build(logic [5:0] op, logic [5:0] funct, logic zero, int fs, int ms);
    ctl_t v;
    int   code;
    exp_q.delete();
    v = idle(); v.alusrcb = 2'b01;
    for (int i = 0; i < fs; i++) push(1'b0, v, 1'b0);
    v.irwrite = 1'b1; v.pcen = 1'b1;
    push(1'b1, v, 1'b0);
    v = idle(); v.alusrcb = 2'b11;
    case (op)
      6'b100011, 6'b101011: begin
        push(rnd_bit(), v, 1'b0);
        v = idle(); v.alusrca = 1'b1; v.alusrcb = 2'b10;
        push(rnd_bit(), v, 1'b1);
        v = idle(); v.iord = 1'b1; v.memwrite = (op == 6'b101011);
        for (int i = 0; i < ms; i++) push(1'b0, v, 1'b1);
        push(1'b1, v, 1'b1);
        if (op == 6'b100011) begin
          v = idle(); v.memtoreg = 1'b1; v.regwrite = 1'b1;
          push(rnd_bit(), v, 1'b1);
        end
      end
      6'b000000: begin
        push(rnd_bit(), v, 1'b0);
        code = rt_code(funct);
        v = idle(); v.alusrca = 1'b1;
        if (code < 0) begin
          v.illegal = 1'b1;
          push(rnd_bit(), v, 1'b1);
        end else begin
          v.alu_ctl = 4'(code);
          push(rnd_bit(), v, 1'b1);
          v = idle(); v.regdst = 1'b1; v.regwrite = 1'b1;
          push(rnd_bit(), v, 1'b1);
        end
      end
      6'b000100, 6'b000101: begin
        push(rnd_bit(), v, 1'b0);
        v = idle(); v.alusrca = 1'b1; v.alu_ctl = 4'd0; v.pcsrc = 2'b01;
        v.pcen = (op == 6'b000100) ? zero : !zero;
        push(rnd_bit(), v, 1'b1);
      end
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: begin
        push(rnd_bit(), v, 1'b0);
        v = idle(); v.alusrca = 1'b1; v.alusrcb = 2'b10;
        case (op)
          6'b001010: v.alu_ctl = 4'd7;
          6'b001100: begin v.alu_ctl = 4'd10; v.ext_zero = 1'b1; end
          6'b001101: begin v.alu_ctl = 4'd1;  v.ext_zero = 1'b1; end
          6'b001110: begin v.alu_ctl = 4'd13; v.ext_zero = 1'b1; end
          default:   v.alu_ctl = 4'd2;
        endcase
        push(rnd_bit(), v, 1'b1);
        v = idle(); v.regwrite = 1'b1;
        push(rnd_bit(), v, 1'b1);
      end
      6'b000010: begin
        push(rnd_bit(), v, 1'b0);
        v = idle(); v.pcsrc = 2'b10; v.pcen = 1'b1;
        push(rnd_bit(), v, 1'b1);
      end
      default: begin
        v.illegal = 1'b1;
        push(rnd_bit(), v, 1'b0);
      end
    endcase
  endfunction

  task automatic check_vec(string tag, ctl_t exp);
    ctl_t got;
    got = observed();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_strobes(string tag);
    logic [4:0] got;
    got = {bus.memwrite, bus.irwrite, bus.regwrite, bus.pcen, bus.illegal};
    checks++;
    assert (got === 5'b0) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, 5'b0);
    end
  endtask

  // Entered just after a rising edge that left the DUT in FETCH.
  task automatic run(string name, logic [5:0] op, logic [5:0] funct, logic zero,
                     int fs, int ms, bit scramble);
    build(op, funct, zero, fs, ms);
    bus.op = op; bus.funct = funct; bus.zero = zero;
    foreach (exp_q[i]) begin
      bus.mem_ready = exp_q[i].mr;
      if (scramble && exp_q[i].scr) begin
        bus.op    = 6'($urandom);
        bus.funct = 6'($urandom);
      end
      @(negedge clk);
      check_vec($sformatf("%s op=%b f=%b cyc%0d", name, op, funct, i + 1), exp_q[i].v);
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] ops [16] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100, 6'b000101,
                           6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b000010,
                           6'b111111, 6'b000001, 6'b100000, 6'b001111};
  logic [5:0] functs [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                             6'b100111, 6'b101010, 6'b000000, 6'b100001};

  initial begin
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.op = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check_strobes($sformatf("reset_strobes%0d", i));
    end
    @(posedge clk); #1;
    reset = 1'b0;

    run("lw",       6'b100011, 6'b0,      1'b0, 0, 0, 0);
    run("r_sub",    6'b000000, 6'b100010, 1'b0, 0, 0, 0);
    run("r_slt",    6'b000000, 6'b101010, 1'b0, 0, 0, 1);
    run("r_bad",    6'b000000, 6'b000000, 1'b0, 0, 0, 0);
    run("beq_z1",   6'b000100, 6'b0,      1'b1, 0, 0, 0);
    run("beq_z0",   6'b000100, 6'b0,      1'b0, 0, 0, 0);
    run("bne_z0",   6'b000101, 6'b0,      1'b0, 0, 0, 1);
    run("sw_stall", 6'b101011, 6'b0,      1'b0, 0, 3, 0);
    run("fetch_st", 6'b001000, 6'b0,      1'b0, 2, 0, 0);
    run("ori",      6'b001101, 6'b0,      1'b0, 0, 0, 0);
    run("j",        6'b000010, 6'b0,      1'b0, 0, 0, 1);
    run("bad_op",   6'b111111, 6'b0,      1'b0, 0, 0, 0);

    // Reset lands while an ORI is in its execute cycle.
    build(6'b001101, 6'b0, 1'b0, 0, 0);
    bus.op = 6'b001101;
    for (int i = 0; i < 2; i++) begin
      bus.mem_ready = exp_q[i].mr;
      @(negedge clk);
      check_vec($sformatf("ori_rst cyc%0d", i + 1), exp_q[i].v);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check_strobes("ori_rst_in_immex");
    @(posedge clk); #1;
    reset = 1'b0;
    run("after_rst", 6'b100011, 6'b0, 1'b0, 0, 1, 0);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] rop, rfn;
      rop = ops[$urandom_range(0, 15)];
      rfn = functs[$urandom_range(0, 8)];
      run($sformatf("rand%0d", n), rop, rfn, rnd_bit(),
          $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
